// File: rtl/dpd_digit_streamer.sv
// dpd_digit_streamer: streams the nine BCD digits of packed DPD words out one at a time
// Ports:
//   clk, rst_n               clock and async active-low reset
//   start, len               begin a run of len digits (sampled in IDLE)
//   abort                    cancel the current run without a done pulse
//   in_word/in_valid/in_ready   three packed declets, [29:20] emitted first
//   out_digit/out_valid/out_ready/out_last   digit stream, out_last on the final digit
//   busy, done               busy while running, done pulses after the final digit
module dpd_digit_streamer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [29:0]      in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [35:0] buf_q;
  logic [35:0] dec;
  logic [3:0] bcnt_q;
  logic [LEN_W-1:0] rem_q;
  logic done_q, go, zero_run, kill, in_hs, out_hs, fin;
  // buffer head sits in the top nibble; declet 0 hundreds lands there
  for (genvar g = 0; g < 3; g++) begin : g_dec
    dpd_declet_decoder u_dec (
      .declet(in_word[29-10*g -: 10]),
      .digits(dec[35-12*g -: 12])
    );
  end
  always_comb begin
    state_d = state_q;
    busy = state_q == RUN;
    go = !busy && start && len != '0;
    zero_run = !busy && start && len == '0;
    kill = busy && abort;
    out_valid = busy && bcnt_q != 4'd0;
    out_digit = buf_q[35:32];
    out_last = out_valid && rem_q == LEN_W'(1);
    // refill while the last buffered digit leaves, unless that digit ends the run
    in_ready = busy && (bcnt_q == 4'd0 || (bcnt_q == 4'd1 && out_ready && rem_q != LEN_W'(1)));
    in_hs = in_ready && in_valid && !abort;
    out_hs = out_valid && out_ready && !abort;
    fin = out_hs && out_last;
    state_d = go ? RUN : (kill || fin) ? IDLE : state_q;
    done = done_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q <= '0;
      bcnt_q <= 4'd0;
      rem_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= zero_run || fin;
      if (go) begin
        rem_q <= len;
        bcnt_q <= 4'd0;
      end else if (kill || fin) begin
        buf_q <= '0;
        bcnt_q <= 4'd0;
        rem_q <= fin ? '0 : rem_q;
      end else begin
        if (in_hs) begin
          buf_q <= dec;
          bcnt_q <= 4'd9;
        end else if (out_hs) begin
          buf_q <= {buf_q[31:0], 4'h0};
          bcnt_q <= bcnt_q - 4'd1;
        end
        if (out_hs) rem_q <= rem_q - LEN_W'(1);
      end
    end
  end
endmodule

// dpd_declet_decoder: 10-bit densely packed decimal declet to three BCD digits
// Ports: declet in; digits[2] hundreds, digits[1] tens, digits[0] units
module dpd_declet_decoder (
  input  logic [9:0]      declet,
  output logic [2:0][3:0] digits
);
  logic p, q, r, s, t, u, v, w, x, y;
  assign {p, q, r, s, t, u, v, w, x, y} = declet;
  // non-canonical codes fall out of the same table with no error flag
  always_comb begin
    digits = {{1'b0, p, q, r}, {1'b0, s, t, u}, {1'b0, w, x, y}};
    if (v)
      case ({w, x})
        2'b00: digits = {{1'b0, p, q, r}, {1'b0, s, t, u}, {3'b100, y}};
        2'b01: digits = {{1'b0, p, q, r}, {3'b100, u}, {1'b0, s, t, y}};
        2'b10: digits = {{3'b100, r}, {1'b0, s, t, u}, {1'b0, p, q, y}};
        default:
          case ({s, t})
            2'b00: digits = {{3'b100, r}, {3'b100, u}, {1'b0, p, q, y}};
            2'b01: digits = {{3'b100, r}, {1'b0, p, q, u}, {3'b100, y}};
            2'b10: digits = {{1'b0, p, q, r}, {3'b100, u}, {3'b100, y}};
            default: digits = {{3'b100, r}, {3'b100, u}, {3'b100, y}};
          endcase
      endcase
  end
endmodule

// File: tb/tb_dpd_digit_streamer.sv
// tb_dpd_digit_streamer: directed self-checking bench for dpd_digit_streamer
module tb_dpd_digit_streamer;
  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [15:0] len;
  logic [29:0] in_word;
  logic [3:0] out_digit;
  int checks = 0;
  int errors = 0;
  logic [29:0] w1 = 30'h0A33FC00;
  logic [29:0] w2 = {10'h256, 10'h07D, 10'h28A};
  logic [3:0] d1 [9] = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
  logic [3:0] d2 [9] = '{4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd1, 4'd5, 4'd8, 4'd0};
  logic [15:0] pat = 16'b1011_0010_1100_1101;
  int idx;

  dpd_digit_streamer #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_digit(out_digit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; start = 0; len = 0; abort = 0; in_word = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    // len=9, one word, consumer always ready
    step; start = 1; len = 9; #1;
    chk("idle_in_ready", in_ready, 0);
    step; start = 0; in_word = w1; in_valid = 1; out_ready = 1; #1;
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_valid0", out_valid, 0);
    for (int i = 0; i < 9; i++) begin
      step; in_valid = 0; #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_digit", out_digit, d1[i]);
      chk("t1_last", out_last, i == 8);
      chk("t1_in_ready", in_ready, 0);
    end
    step;
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_out_valid_end", out_valid, 0);
    step;
    chk("t1_done_off", done, 0);
    // len=4, rest of word discarded, no refill
    start = 1; len = 4;
    step; start = 0; in_word = w1; in_valid = 1; #1;
    for (int i = 0; i < 4; i++) begin
      step; #1;
      chk("t2_digit", out_digit, d1[i]);
      chk("t2_last", out_last, i == 3);
      chk("t2_in_ready", in_ready, 0);
    end
    step;
    chk("t2_done", done, 1);
    chk("t2_in_ready_end", in_ready, 0);
    chk("t2_busy_end", busy, 0);
    in_valid = 0;
    // len=18, two words back-to-back
    step; start = 1; len = 18;
    step; start = 0; in_word = w1; in_valid = 1; #1;
    for (int i = 0; i < 18; i++) begin
      step;
      if (i == 0) in_word = w2;
      if (i == 9) in_valid = 0;
      #1;
      chk("t3_valid", out_valid, 1);
      chk("t3_digit", out_digit, i < 9 ? d1[i] : d2[i-9]);
      chk("t3_last", out_last, i == 17);
      chk("t3_in_ready", in_ready, i == 8);
    end
    step;
    chk("t3_done", done, 1);
    // consumer stalls in a fixed irregular pattern
    step; start = 1; len = 9;
    step; start = 0; in_word = w1; in_valid = 1; out_ready = 0;
    step; in_valid = 0;
    idx = 0;
    for (int k = 0; k < 64 && idx < 9; k++) begin
      out_ready = pat[k%16];
      #1;
      chk("t4_valid", out_valid, 1);
      chk("t4_digit", out_digit, d1[idx]);
      chk("t4_last", out_last, idx == 8);
      if (out_ready) idx++;
      step;
    end
    chk("t4_count", idx, 9);
    chk("t4_done", done, 1);
    out_ready = 1;
    // len=0: done pulse only
    step; start = 1; len = 0; #1;
    chk("t5_in_ready", in_ready, 0);
    step; start = 0; #1;
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready2", in_ready, 0);
    chk("t5_out_valid", out_valid, 0);
    step;
    chk("t5_done_off", done, 0);
    // abort in IDLE alongside start has no effect; abort after 3 digits
    start = 1; len = 9; abort = 1;
    step; start = 0; abort = 0; in_word = w1; in_valid = 1; #1;
    chk("t6_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step; in_valid = 0; #1;
      chk("t6_digit", out_digit, d1[i]);
    end
    step; #1;
    chk("t6_digit4", out_digit, d1[3]);
    abort = 1;
    step; abort = 0; #1;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_valid", out_valid, 0);
    chk("t6_abort_done", done, 0);
    step;
    chk("t6_abort_done2", done, 0);
    // abort beats a same-cycle input handshake
    start = 1; len = 9;
    step; start = 0; in_word = w1; in_valid = 1; abort = 1; #1;
    chk("t7_in_ready", in_ready, 1);
    step; abort = 0; in_valid = 0; #1;
    chk("t7_busy", busy, 0);
    chk("t7_valid", out_valid, 0);
    step;
    chk("t7_done", done, 0);
    // reset mid-run
    start = 1; len = 9;
    step; start = 0; in_valid = 1;
    step; in_valid = 0; #1;
    chk("t8_digit", out_digit, d1[0]);
    step; rst_n = 0; #1;
    chk("t8_busy", busy, 0);
    chk("t8_valid", out_valid, 0);
    chk("t8_last", out_last, 0);
    chk("t8_in_ready", in_ready, 0);
    chk("t8_done", done, 0);
    chk("t8_digit0", out_digit, 0);
    step; rst_n = 1;
    step; step;
    chk("t8_busy_after", busy, 0);
    chk("t8_valid_after", out_valid, 0);
    chk("t8_done_after", done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpd_digit_streamer.md
DPD_DIGIT_STREAMER -- requirements
Module: dpd_digit_streamer

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the digit-count input and of the internal remaining-digit counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a run; sampled only in IDLE.
REQ-005 SHALL have port len, input, LEN_W: number of BCD digits to emit in the run; sampled with start.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the current run.
REQ-007 SHALL have port in_word, input, 30: three packed DPD declets; [29:20] is declet 0, [19:10] is declet 1, [9:0] is declet 2.
REQ-008 SHALL have port in_valid, input, 1: in_word is valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts in_word this cycle.
REQ-010 SHALL have port out_digit, output, 4: current BCD digit.
REQ-011 SHALL have port out_valid, output, 1: out_digit is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts out_digit.
REQ-013 SHALL have port out_last, output, 1: current digit is the final digit of the run.
REQ-014 SHALL have port busy, output, 1: high in RUN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the final digit handshake.

Function
REQ-016 SHALL decode each declet to three BCD digits with the team's existing 10-bit-to-3-digit DPD decoder, instantiated three times on in_word; no decoding is duplicated locally.
REQ-017 SHALL hold state IDLE or RUN, plus:
- a 9-entry digit buffer
- bcnt, 0..9
- rem, LEN_W bits
REQ-018 SHALL, in IDLE, drive in_ready=0, out_valid=0, busy=0.
REQ-019 SHALL, in IDLE with start=1 and len!=0, load rem<=len and bcnt<=0, and enter RUN next cycle.
REQ-020 SHALL, in IDLE with start=1 and len==0, stay in IDLE and pulse done for one cycle next cycle.
REQ-021 SHALL ignore start while in RUN.
REQ-022 SHALL set the emit order to: declet 0 hundreds, tens, units; then declet 1; then declet 2. The hundreds digit is decoder digit index 2.
REQ-023 SHALL, in RUN, drive:
- out_valid = (bcnt!=0)
- out_digit = buffer head
- out_last = out_valid && rem==1
REQ-024 SHALL, in RUN, drive in_ready = (bcnt==0) || (bcnt==1 && out_ready && rem!=1); this gives back-to-back words with no bubble.
REQ-025 SHALL, on input handshake, load all 9 decoded digits and set bcnt<=9; a simultaneous output handshake of the old last digit is still counted.
REQ-026 SHALL, on output handshake, shift the buffer by one digit and decrement bcnt and rem.
REQ-027 SHALL, on output handshake with rem==1:
- discard the remaining buffered digits
- set bcnt<=0
- return to IDLE
- pulse done on the next cycle
REQ-028 SHALL hold out_digit, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-029 SHALL give a first-digit latency of one cycle: out_valid rises the cycle after the input handshake.
REQ-030 SHALL, on abort=1 in RUN:
- return to IDLE next cycle
- clear bcnt
- drop buffered digits
- not assert done
REQ-031 SHALL give abort priority over a same-cycle input or output handshake: neither handshake takes effect.
REQ-032 SHALL have no effect from abort in IDLE.
REQ-033 SHALL decode the non-canonical DPD codes exactly as the shared decoder does, with no error flag.

Reset
REQ-034 SHALL, while rst_n=0, force:
- state=IDLE, bcnt=0, rem=0, buffer=0
- in_ready=0, out_valid=0, out_last=0, busy=0, done=0
REQ-035 SHALL, on reset asserted mid-run, lose all buffered digits; after release the block waits for a new start.

Verification
REQ-036 SHALL cover: start, len=9; word 0x0A33FC00 with out_ready=1 -> digits 1,2,3,9,9,9,0,0,0 on consecutive cycles; out_last on the final 0; done one cycle later.
REQ-037 SHALL cover: len=4, same word -> digits 1,2,3,9; remaining digits discarded; in_ready never reasserted; done pulses.
REQ-038 SHALL cover: len=18, two words presented back-to-back, out_ready=1 -> 18 digits with no gap; second in_ready seen in the cycle the 9th digit is taken.
REQ-039 SHALL cover: out_ready toggled randomly -> out_digit stable while stalled; digit sequence unchanged.
REQ-040 SHALL cover: start, len=0 -> done pulse only; in_ready and out_valid stay 0.
REQ-041 SHALL cover: abort after 3 digits, then rst_n pulse in a new run -> IDLE; no done; all outputs 0.
